// File: rtl/cl_sertfg_uart_rx.sv
// -----------------------------------------------------------------------------
// cl_sertfg_uart_rx
// Receive side of the CameraLink serial-control channel. Recovers 8N1 UART
// bytes sent by the camera on SerTFG and presents them to the host serial
// bridge through a one-deep holding register with a valid/ready handshake.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 8)
//   CNT_W         bit-timing counter width, 2**CNT_W > CLKS_PER_BIT
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sertfg_in    single-ended SerTFG line from the LVDS buffer (idles high)
//   rx_data      held byte, LSB received first
//   rx_valid     rx_data holds an unconsumed byte
//   rx_ready     consumer accepts the byte when rx_valid && rx_ready
//   framing_err  one-cycle pulse when the stop bit is sampled low
//   overrun      sticky: a byte was dropped because the holding register was full
//   ovr_clr      clears overrun
//
// Build option:
//   YV_SERTFG_MAJORITY_EN  when defined, every bit decision is the 2-of-3
//                          majority of the line around the nominal sample
//                          point, taken one cycle late.
// -----------------------------------------------------------------------------
module cl_sertfg_uart_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sertfg_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun,
  input  logic       ovr_clr
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

`ifdef YV_SERTFG_MAJORITY_EN
  // One extra cycle on the first load moves every decision to nominal+1,
  // where the samples at nominal-1, nominal and nominal+1 are all available.
  localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(CLKS_PER_BIT / 2 + 1);
`else
  localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(CLKS_PER_BIT / 2);
`endif
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef YV_SERTFG_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  logic             sync1_r;
  logic             s_r;
  logic             s_d_r;
`ifdef YV_SERTFG_MAJORITY_EN
  logic             s_d2_r;
`endif
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;

  logic             sample_s;
  logic             fall_s;
  logic             expire_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             idx_clr_s;
  logic             shift_en_s;
  logic             deliver_s;
  logic             frame_err_s;

`ifdef YV_SERTFG_MAJORITY_EN
  assign sample_s = maj3(s_d2_r, s_d_r, s_r);
`else
  assign sample_s = s_r;
`endif
  // Start edge is detected against the previous synchronized value.
  assign fall_s   = s_d_r & ~s_r;
  assign expire_s = (cnt_r == CNT_ONE);

  // Two-flop synchronizer plus delayed copies for edge detection / voting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      s_r     <= 1'b1;
      s_d_r   <= 1'b1;
`ifdef YV_SERTFG_MAJORITY_EN
      s_d2_r  <= 1'b1;
`endif
    end else begin
      sync1_r <= sertfg_in;
      s_r     <= sync1_r;
      s_d_r   <= s_r;
`ifdef YV_SERTFG_MAJORITY_EN
      s_d2_r  <= s_d_r;
`endif
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = BIT_LOAD;
    idx_clr_s      = 1'b0;
    shift_en_s     = 1'b0;
    deliver_s      = 1'b0;
    frame_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s    = ST_START;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = FIRST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (expire_s) begin
          if (sample_s) begin
            // Line back high mid start bit: glitch, not a frame.
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
            cnt_load_s  = 1'b1;
            idx_clr_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (expire_s) begin
          shift_en_s = 1'b1;
          cnt_load_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (expire_s) begin
          if (sample_s) begin
            // Returning at mid stop bit leaves room to catch the next start edge.
            deliver_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (s_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bit-timing counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (cnt_load_s) begin
        cnt_r <= cnt_load_val_s;
      end else if (cnt_r > CNT_ONE) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (idx_clr_s) begin
        bit_idx_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
      if (shift_en_s) begin
        shift_r[bit_idx_r] <= sample_s;
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // Holding register, handshake and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= frame_err_s;
      if (deliver_s) begin
        // A same-cycle consume frees the register for the new byte.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          rx_data  <= rx_data;
          rx_valid <= rx_valid;
        end
      end else if (rx_valid && rx_ready) begin
        rx_data  <= rx_data;
        rx_valid <= 1'b0;
      end else begin
        rx_data  <= rx_data;
        rx_valid <= rx_valid;
      end
      // A new overrun wins over a simultaneous clear.
      if (deliver_s && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_cl_sertfg_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_cl_sertfg_uart_rx
// Directed bench for cl_sertfg_uart_rx at CLKS_PER_BIT = 16. A frame-level
// model predicts, for every frame sent, the cycle at which the byte (or the
// framing error) must appear, and applies the holding-register handshake
// rules to produce the expected outputs every cycle.
// -----------------------------------------------------------------------------
module tb_cl_sertfg_uart_rx;

  localparam int C = 16;
`ifdef YV_SERTFG_MAJORITY_EN
  localparam int LAT = 156;               // 2 + 8 + 144 + 1 + 1
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int LAT = 155;               // 2 + 8 + 144 + 1
  localparam logic [7:0] GLITCH_EXP = 8'h01;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sertfg_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       framing_err;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  cl_sertfg_uart_rx #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sertfg_in(sertfg_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .framing_err(framing_err), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Cycle index: cycle k is the interval after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected frame outcomes: visible cycle, framing error flag, byte.
  typedef struct {
    int         vcyc;
    bit         fe;
    logic [7:0] b;
  } ev_t;
  ev_t evq[$];

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  // Frame-level model of the holding register and flags.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      evq.delete();
    end else begin
      bit         dlv;
      bit         fe;
      logic [7:0] nb;
      ev_t        ev;
      dlv = 1'b0;
      fe  = 1'b0;
      nb  = 8'h00;
      if (evq.size() > 0 && evq[0].vcyc == cyc + 1) begin
        ev = evq.pop_front();
        if (ev.fe) fe = 1'b1;
        else begin
          dlv = 1'b1;
          nb  = ev.b;
        end
      end
      m_ferr <= fe;
      if (dlv && (!m_valid || rx_ready)) begin
        m_data  <= nb;
        m_valid <= 1'b1;
      end else if (!dlv && m_valid && rx_ready) begin
        m_valid <= 1'b0;
      end
      if (dlv && m_valid && !rx_ready) m_ovr <= 1'b1;
      else if (ovr_clr) m_ovr <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
    check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
    check("framing_err", {31'd0, framing_err}, {31'd0, m_ferr});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  end

  // Event monitor used by the literal timing checks.
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   hi_cnt   = 0;
  int   fe_cnt   = 0;
  logic prev_v   = 1'b0;
  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (rx_valid) hi_cnt <= hi_cnt + 1;
    if (framing_err) fe_cnt <= fe_cnt + 1;
    prev_v <= rx_valid;
  end

  // All driving tasks are entered and left 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    sertfg_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t ev;
    ev.vcyc = cyc + LAT;
    ev.fe   = !stop;
    ev.b    = b;
    evq.push_back(ev);
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(b[i], C);
    drive(stop, C);
  endtask

  initial begin
    int e0;
    int h0;
    int r0;
    int f0;
    ev_t ev;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_ferr", {31'd0, framing_err}, 32'd0);
    check("reset_ovr", {31'd0, overrun}, 32'd0);
    drive(1'b1, 5);

    // 0xA5 with rx_ready held high: one-cycle valid at the fixed latency.
    rx_ready = 1'b1;
    e0 = cyc;
    h0 = hi_cnt;
    f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 5);
    check("a5_latency", rise_cyc - e0, LAT);
    check("a5_valid_cycles", hi_cnt - h0, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_no_ferr", fe_cnt - f0, 32'd0);

    // Back-to-back 0x3C, 0xC3 with no consumer: overrun, first byte held.
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    drive(1'b1, 3);
    check("ovr_data", {24'd0, rx_data}, 32'h3C);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    drive(1'b1, 1);
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
    rx_ready = 1'b1;
    drive(1'b1, 3);

    // 0x55 with a low stop bit, line held low, then 0x12.
    r0 = rise_cnt;
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 20);
    check("fe_pulses", fe_cnt - f0, 32'd1);
    check("fe_no_valid", rise_cnt - r0, 32'd0);
    send_frame(8'h12, 1'b1);
    drive(1'b1, 5);
    check("after_break_data", {24'd0, rx_data}, 32'h12);

    // Three-cycle low glitch: false start, then 0x7E held for the next step.
    r0 = rise_cnt;
    drive(1'b0, 3);
    drive(1'b1, 30);
    check("glitch_no_valid", rise_cnt - r0, 32'd0);
    rx_ready = 1'b0;
    send_frame(8'h7E, 1'b1);
    drive(1'b1, 5);
    check("after_glitch_data", {24'd0, rx_data}, 32'h7E);
    check("after_glitch_valid", {31'd0, rx_valid}, 32'd1);

    // Reset at the bit-4 sample of 0x81 clears everything immediately.
    drive(1'b0, C);
    drive(1'b1, C);
    drive(1'b0, C);
    drive(1'b0, C);
    drive(1'b0, C);
    drive(1'b0, 10);
    rst = 1'b1;
    sertfg_in = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_mid_data", {24'd0, rx_data}, 32'h00);
    check("rst_mid_ferr", {31'd0, framing_err}, 32'd0);
    check("rst_mid_ovr", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_ready = 1'b1;
    drive(1'b1, 5);
    send_frame(8'h81, 1'b1);
    drive(1'b1, 5);
    check("after_rst_data", {24'd0, rx_data}, 32'h81);

    // 0x00 with a one-cycle high glitch exactly at the bit-0 nominal sample.
    ev.vcyc = cyc + LAT;
    ev.fe   = 1'b0;
    ev.b    = GLITCH_EXP;
    evq.push_back(ev);
    drive(1'b0, C);
    drive(1'b0, 8);
    drive(1'b1, 1);
    drive(1'b0, 7);
    for (int i = 1; i < 8; i++) drive(1'b0, C);
    drive(1'b1, C);
    drive(1'b1, 5);
    check("bit0_glitch_data", {24'd0, rx_data}, {24'd0, GLITCH_EXP});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
